// File: rtl/program_loader.sv
// Boot-time program loader: answers the state controller's loader commands by
// sending sync/ack bytes over the UART and streaming the program into instruction memory.
module program_loader #(
    parameter int ADDR_WIDTH = 15
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  transmit_0x99,
    input  logic                  receive_program_data_size,
    input  logic                  receive_program_data,
    input  logic                  transmit_0xAA,
    output logic                  transmit_0x99_finished,
    output logic                  receive_program_data_size_finished,
    output logic                  receive_program_data_finished,
    output logic                  transmit_0xAA_finished,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    input  logic                  tx_ready,
    output logic                  tx_valid,
    output logic [7:0]            tx_data,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic [31:0]           program_size
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        TX      = 3'd1,
        RX_SIZE = 3'd2,
        RX_DATA = 3'd3,
        FLUSH   = 3'd4,
        DONE    = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        CMD_99   = 2'd0,
        CMD_SIZE = 2'd1,
        CMD_DATA = 2'd2,
        CMD_AA   = 2'd3
    } cmd_t;

    state_t                  state_r, state_s;
    cmd_t                    cmd_r, cmd_s;
    logic [31:0]             byte_cnt_r, byte_cnt_s;
    logic [31:0]             word_r, word_s;
    logic [31:0]             size_r, size_s;
    logic                    tx_valid_r, tx_valid_s;
    logic [7:0]              tx_data_r, tx_data_s;
    logic                    imem_we_r, imem_we_s;
    logic [ADDR_WIDTH-1:0]   imem_addr_r, imem_addr_s;
    logic [31:0]             imem_wdata_r, imem_wdata_s;
    logic [3:0]              fin_r, fin_s;

    logic [3:0]              cmd_vec_s;
    logic [1:0]              lane_s;
    logic [31:0]             cnt_inc_s;
    logic [31:0]             word_ins_s;
    logic                    in_range_s;

    // Places a byte into the selected little-endian lane of a word.
    function automatic logic [31:0] insert_byte(input logic [31:0] word,
                                                input logic [1:0]  lane,
                                                input logic [7:0]  b);
        logic [31:0] r;
        r = word;
        case (lane)
            2'd0:    r[7:0]   = b;
            2'd1:    r[15:8]  = b;
            2'd2:    r[23:16] = b;
            2'd3:    r[31:24] = b;
            default: r        = word;
        endcase
        return r;
    endfunction

    assign cmd_vec_s  = {transmit_0xAA, receive_program_data, receive_program_data_size, transmit_0x99};
    assign lane_s     = byte_cnt_r[1:0];
    assign cnt_inc_s  = byte_cnt_r + 32'd1;
    // A new word starts from zero so a trailing partial word has its upper bytes cleared.
    assign word_ins_s = insert_byte((lane_s == 2'd0) ? 32'h0000_0000 : word_r, lane_s, rx_data);
    assign in_range_s = (byte_cnt_r[31:ADDR_WIDTH+2] == '0);

    // Next-state and next-output logic.
    always_comb begin
        state_s      = state_r;
        cmd_s        = cmd_r;
        byte_cnt_s   = byte_cnt_r;
        word_s       = word_r;
        size_s       = size_r;
        tx_valid_s   = tx_valid_r;
        tx_data_s    = tx_data_r;
        imem_we_s    = 1'b0;
        imem_addr_s  = imem_addr_r;
        imem_wdata_s = imem_wdata_r;
        fin_s        = 4'b0000;
        case (state_r)
            IDLE: begin
                byte_cnt_s = 32'd0;
                word_s     = 32'h0000_0000;
                if (transmit_0x99) begin
                    state_s    = TX;
                    cmd_s      = CMD_99;
                    tx_valid_s = 1'b1;
                    tx_data_s  = 8'h99;
                end else if (receive_program_data_size) begin
                    state_s = RX_SIZE;
                    cmd_s   = CMD_SIZE;
                end else if (receive_program_data) begin
                    state_s = RX_DATA;
                    cmd_s   = CMD_DATA;
                end else if (transmit_0xAA) begin
                    state_s    = TX;
                    cmd_s      = CMD_AA;
                    tx_valid_s = 1'b1;
                    tx_data_s  = 8'hAA;
                end else begin
                    state_s = IDLE;
                end
            end
            TX: begin
                if (tx_ready) begin
                    tx_valid_s    = 1'b0;
                    tx_data_s     = 8'h00;
                    fin_s[cmd_r]  = 1'b1;
                    state_s       = DONE;
                end else begin
                    state_s = TX;
                end
            end
            RX_SIZE: begin
                if (rx_valid) begin
                    word_s     = word_ins_s;
                    byte_cnt_s = cnt_inc_s;
                    if (lane_s == 2'd3) begin
                        size_s          = word_ins_s;
                        fin_s[CMD_SIZE] = 1'b1;
                        state_s         = DONE;
                    end else begin
                        state_s = RX_SIZE;
                    end
                end else begin
                    state_s = RX_SIZE;
                end
            end
            RX_DATA: begin
                if (byte_cnt_r == size_r) begin
                    fin_s[CMD_DATA] = 1'b1;
                    state_s         = DONE;
                end else if (rx_valid) begin
                    word_s     = word_ins_s;
                    byte_cnt_s = cnt_inc_s;
                    // Last byte of a word, or last byte of the program: commit the word.
                    if ((lane_s == 2'd3) || (cnt_inc_s == size_r)) begin
                        imem_we_s    = in_range_s;
                        imem_addr_s  = byte_cnt_r[ADDR_WIDTH+1:2];
                        imem_wdata_s = word_ins_s;
                    end else begin
                        imem_we_s = 1'b0;
                    end
                    if (cnt_inc_s == size_r) begin
                        state_s = FLUSH;
                    end else begin
                        state_s = RX_DATA;
                    end
                end else begin
                    state_s = RX_DATA;
                end
            end
            FLUSH: begin
                fin_s[CMD_DATA] = 1'b1;
                state_s         = DONE;
            end
            DONE: begin
                if (!cmd_vec_s[cmd_r]) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r      <= IDLE;
            cmd_r        <= CMD_99;
            byte_cnt_r   <= 32'd0;
            word_r       <= 32'h0000_0000;
            size_r       <= 32'd0;
            tx_valid_r   <= 1'b0;
            tx_data_r    <= 8'h00;
            imem_we_r    <= 1'b0;
            imem_addr_r  <= '0;
            imem_wdata_r <= 32'h0000_0000;
            fin_r        <= 4'b0000;
        end else begin
            state_r      <= state_s;
            cmd_r        <= cmd_s;
            byte_cnt_r   <= byte_cnt_s;
            word_r       <= word_s;
            size_r       <= size_s;
            tx_valid_r   <= tx_valid_s;
            tx_data_r    <= tx_data_s;
            imem_we_r    <= imem_we_s;
            imem_addr_r  <= imem_addr_s;
            imem_wdata_r <= imem_wdata_s;
            fin_r        <= fin_s;
        end
    end

    assign transmit_0x99_finished             = fin_r[0];
    assign receive_program_data_size_finished = fin_r[1];
    assign receive_program_data_finished      = fin_r[2];
    assign transmit_0xAA_finished             = fin_r[3];
    assign tx_valid                           = tx_valid_r;
    assign tx_data                            = tx_data_r;
    assign imem_we                            = imem_we_r;
    assign imem_addr                          = imem_addr_r;
    assign imem_wdata                         = imem_wdata_r;
    assign program_size                       = size_r;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: instruction-memory writes are scored against
// a queue of expected {addr, data} pairs filled as bytes are driven.
module tb_program_loader;

    localparam int AW = 15;

    logic          clk;
    logic          reset_n;
    logic          transmit_0x99, receive_program_data_size, receive_program_data, transmit_0xAA;
    logic          fin_99, fin_size, fin_data, fin_aa;
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          tx_ready;
    logic          tx_valid;
    logic [7:0]    tx_data;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic [31:0]   program_size;

    int pass_cnt  = 0;
    int check_cnt = 0;
    int we_cnt    = 0;
    int hs_cnt    = 0;
    int fin99_cnt = 0;
    int finaa_cnt = 0;
    logic [AW+31:0] exp_q[$];

    program_loader #(.ADDR_WIDTH(AW)) dut (
        .clk                                (clk),
        .reset_n                            (reset_n),
        .transmit_0x99                      (transmit_0x99),
        .receive_program_data_size          (receive_program_data_size),
        .receive_program_data               (receive_program_data),
        .transmit_0xAA                      (transmit_0xAA),
        .transmit_0x99_finished             (fin_99),
        .receive_program_data_size_finished (fin_size),
        .receive_program_data_finished      (fin_data),
        .transmit_0xAA_finished             (fin_aa),
        .rx_valid                           (rx_valid),
        .rx_data                            (rx_data),
        .tx_ready                           (tx_ready),
        .tx_valid                           (tx_valid),
        .tx_data                            (tx_data),
        .imem_we                            (imem_we),
        .imem_addr                          (imem_addr),
        .imem_wdata                         (imem_wdata),
        .program_size                       (program_size)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    // Scoreboard side: every write strobe is compared with the oldest expected write.
    always @(negedge clk) begin
        if (tx_valid && tx_ready) hs_cnt++;
        if (fin_99) fin99_cnt++;
        if (fin_aa) finaa_cnt++;
        if (imem_we) begin
            logic [AW+31:0] e;
            we_cnt++;
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("write_addr", 32'(imem_addr), 32'(e[AW+31:32]));
                chk("write_data", imem_wdata, e[31:0]);
            end
        end
    end

    initial begin
        logic [7:0] prog8 [8];
        logic [7:0] prog6 [6];
        prog8 = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        prog6 = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
        reset_n = 1'b0;
        transmit_0x99 = 1'b0; receive_program_data_size = 1'b0;
        receive_program_data = 1'b0; transmit_0xAA = 1'b0;
        rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0;
        tick(); tick();
        @(negedge clk);
        chk("reset_outputs", {27'd0, tx_valid, imem_we, fin_99, fin_size, fin_data | fin_aa}, 32'd0);
        chk("reset_size", program_size, 32'd0);
        reset_n = 1'b1;
        tick();

        // 0x99 send with transmitter stalled for 3 cycles
        transmit_0x99 = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("tx99_hold", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'h99});
            tick();
        end
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        @(negedge clk);
        chk("tx99_finished", 32'(fin_99), 32'd1);
        chk("tx99_valid_drop", 32'(tx_valid), 32'd0);
        for (int i = 0; i < 4; i++) tick();
        @(negedge clk);
        chk("tx99_no_resend", {23'd0, tx_valid, tx_data}, 32'd0);
        chk("tx99_pulse_count", 32'(fin99_cnt), 32'd1);
        chk("tx99_handshakes", 32'(hs_cnt), 32'd1);
        transmit_0x99 = 1'b0;
        tick(); tick();

        // byte in IDLE is dropped, then size 8
        send_byte(8'h55);
        tick();
        receive_program_data_size = 1'b1;
        tick();
        send_byte(8'h08); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        @(negedge clk);
        chk("size_finished", 32'(fin_size), 32'd1);
        chk("size_value", program_size, 32'd8);
        tick();
        @(negedge clk);
        chk("size_finished_pulse", 32'(fin_size), 32'd0);
        receive_program_data_size = 1'b0;
        tick(); tick();

        // aligned 8-byte program, bytes back to back
        exp_q.push_back({AW'(0), 32'h0000_0013});
        exp_q.push_back({AW'(1), 32'h0010_0093});
        receive_program_data = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) send_byte(prog8[i]);
        @(negedge clk);
        chk("aligned_last_we", 32'(imem_we), 32'd1);
        chk("aligned_not_yet_done", 32'(fin_data), 32'd0);
        tick();
        @(negedge clk);
        chk("aligned_finished", 32'(fin_data), 32'd1);
        chk("aligned_we_pulse", 32'(imem_we), 32'd0);
        receive_program_data = 1'b0;
        tick(); tick();

        // size 6 and partial trailing word
        receive_program_data_size = 1'b1;
        tick();
        send_byte(8'h06); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        receive_program_data_size = 1'b0;
        tick(); tick();
        @(negedge clk);
        chk("size6_value", program_size, 32'd6);
        exp_q.push_back({AW'(0), 32'hDDCC_BBAA});
        exp_q.push_back({AW'(1), 32'h0000_FFEE});
        receive_program_data = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) send_byte(prog6[i]);
        @(negedge clk);
        chk("partial_flush_we", 32'(imem_we), 32'd1);
        tick();
        @(negedge clk);
        chk("partial_finished", 32'(fin_data), 32'd1);
        receive_program_data = 1'b0;
        tick(); tick();
        chk("writes_so_far", 32'(we_cnt), 32'd4);

        // empty program
        receive_program_data_size = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) send_byte(8'h00);
        receive_program_data_size = 1'b0;
        tick(); tick();
        receive_program_data = 1'b1;
        tick();
        @(negedge clk);
        chk("empty_not_yet", 32'(fin_data), 32'd0);
        tick();
        @(negedge clk);
        chk("empty_finished", 32'(fin_data), 32'd1);
        receive_program_data = 1'b0;
        tick(); tick();
        chk("empty_no_writes", 32'(we_cnt), 32'd4);

        // reset after 5 of 8 bytes
        receive_program_data_size = 1'b1;
        tick();
        send_byte(8'h08); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        receive_program_data_size = 1'b0;
        tick(); tick();
        exp_q.push_back({AW'(0), 32'h0403_0201});
        receive_program_data = 1'b1;
        tick();
        for (int i = 1; i <= 5; i++) send_byte(8'(i));
        receive_program_data = 1'b0;
        reset_n = 1'b0;
        tick();
        @(negedge clk);
        chk("midreset_outputs", {27'd0, tx_valid, imem_we, fin_99, fin_size, fin_data | fin_aa}, 32'd0);
        chk("midreset_size", program_size, 32'd0);
        chk("midreset_wdata", imem_wdata, 32'd0);
        reset_n = 1'b1;
        tick();
        send_byte(8'h06); send_byte(8'h07); send_byte(8'h08);
        tick(); tick();
        chk("midreset_no_more_writes", 32'(we_cnt), 32'd5);

        // 0xAA after reset, transmitter ready immediately
        transmit_0xAA = 1'b1;
        tx_ready      = 1'b1;
        tick();
        @(negedge clk);
        chk("txaa_offer", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'hAA});
        tick();
        tx_ready = 1'b0;
        @(negedge clk);
        chk("txaa_finished", 32'(fin_aa), 32'd1);
        tick(); tick();
        transmit_0xAA = 1'b0;
        tick();
        chk("txaa_pulse_count", 32'(finaa_cnt), 32'd1);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Boot-time responder to the CPU state controller's loader handshake.
- Executes each boot command: send the 0x99 sync byte, receive the 4-byte program size, stream program bytes into instruction memory, send the 0xAA ack byte.
- Signals completion of each command to the controller with a one-cycle finished pulse.
- Sits between the state controller, the UART rx/tx byte interfaces and the instruction-memory write port.

Parameters:
- ADDR_WIDTH, 15: instruction-memory word-address width; capacity is 2^ADDR_WIDTH 32-bit words.

Ports:
- clk  input  1  clock
- reset_n  input  1  synchronous, active-low reset
- transmit_0x99  input  1  command level: send 0x99
- receive_program_data_size  input  1  command level: receive size
- receive_program_data  input  1  command level: receive program
- transmit_0xAA  input  1  command level: send 0xAA
- transmit_0x99_finished  output  1  one-cycle completion pulse
- receive_program_data_size_finished  output  1  one-cycle completion pulse
- receive_program_data_finished  output  1  one-cycle completion pulse
- transmit_0xAA_finished  output  1  one-cycle completion pulse
- rx_valid  input  1  one-cycle strobe, rx_data holds a received byte
- rx_data  input  8  received byte
- tx_ready  input  1  UART transmitter can accept a byte
- tx_valid  output  1  byte offered to transmitter
- tx_data  output  8  byte offered
- imem_we  output  1  instruction-memory write strobe
- imem_addr  output  ADDR_WIDTH  word address
- imem_wdata  output  32  word data
- program_size  output  32  latched program size in bytes

Behaviour:
- Reset (reset_n low at a clk edge): state IDLE; all outputs 0; byte counter, word shift register and program_size cleared. Applies mid-operation; a partial word is discarded.
- States: IDLE, TX, RX_SIZE, RX_DATA, FLUSH, DONE.
- IDLE command priority: transmit_0x99 > receive_program_data_size > receive_program_data > transmit_0xAA. The controller never raises two commands at once.
- TX:
  - tx_valid=1, tx_data=0x99 or 0xAA; both held stable until an edge where tx_valid&tx_ready.
  - The matching finished output is high for exactly the cycle after the handshake edge.
  - The block then enters DONE.
- RX_SIZE:
  - Accepts 4 bytes on rx_valid, little-endian (first byte = bits 7:0).
  - program_size updates at the edge accepting byte 4.
  - receive_program_data_size_finished is high the following cycle.
- RX_DATA, byte handling:
  - Bytes are assembled little-endian into words; byte counter starts at 0.
  - On the edge accepting byte 4n+3, the next cycle has imem_we=1, imem_addr=n, imem_wdata=assembled word.
  - imem_we is a one-cycle pulse.
- RX_DATA, termination:
  - When the byte count reaches program_size with a partial word pending, go to FLUSH. FLUSH writes that word with missing upper bytes zeroed, one cycle after the last byte edge.
  - receive_program_data_finished is high the cycle after the final imem_we.
  - program_size==0: finished is high the cycle after entering RX_DATA; no writes.
- Capacity limit: words with index >= 2^ADDR_WIDTH are consumed but not written (imem_we stays 0); finishing is unaffected.
- DONE: all finished outputs low; return to IDLE once the active command is low, so a held command never re-triggers.
- rx_valid outside RX_SIZE/RX_DATA: byte dropped, no state change.
- rx_valid coinciding with an imem_we cycle: byte accepted normally; write timing is unaffected.
- Command deasserted mid-operation (not legal): the operation completes anyway.

Test Plan:
- 0x99 send: assert transmit_0x99 with tx_ready low 3 cycles, then high. Required: tx_valid=1/tx_data=0x99 held throughout; one handshake; transmit_0x99_finished high exactly 1 cycle after it; no second send while the command stays high.
- Size receive: bytes 08 00 00 00 during receive_program_data_size. Required: program_size=8; finished pulse 1 cycle after byte 4.
- Aligned program: program_size=8, bytes 13 00 00 00 93 00 10 00. Required:
  - imem_we at addr 0 with 0x00000013;
  - imem_we at addr 1 with 0x00100093;
  - finished pulse the cycle after the second write.
- Partial word and empty program:
  - program_size=6, bytes AA BB CC DD EE FF. Required: writes 0xDDCCBBAA@0 and 0x0000FFEE@1.
  - program_size=0. Required: finished with no imem_we.
- Dropped bytes and reset: rx_valid with byte 0x55 while IDLE → ignored; later size receive is unaffected. Assert reset_n low after 5 of 8 data bytes. Required:
  - all outputs 0, no further writes;
  - a new 0xAA command then works normally: tx_data=0xAA, finished pulse after the handshake.
